// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: two-stage valid/ready registered signed adder with carry, overflow and saturating overflow counter
module adder_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] ovf_count_o,
  input  logic             clr_count_i
);
  logic             s1_valid;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   sum_w;
  logic             s2_free, in_xfer, out_xfer, ovf_w;
  always_comb begin
    s2_free    = !out_valid_o | out_ready_i;
    in_ready_o = !s1_valid | s2_free;
    in_xfer    = in_valid_i & in_ready_o;
    out_xfer   = out_valid_o & out_ready_i;
    sum_w      = {1'b0, a_q} + {1'b0, b_q};
    ovf_w      = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_w[WIDTH-1] != a_q[WIDTH-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      carry_o     <= 1'b0;
      overflow_o  <= 1'b0;
      ovf_count_o <= '0;
    end else begin
      if (in_xfer) begin
        a_q <= add1_i;
        b_q <= add2_i;
      end
      s1_valid <= in_xfer | (s1_valid & !s2_free);
      if (s2_free) out_valid_o <= s1_valid;
      if (s2_free & s1_valid) begin
        {carry_o, sum_o} <= sum_w;
        overflow_o       <= ovf_w;
      end
      ovf_count_o <= clr_count_i ? '0 :
                     (out_xfer & overflow_o & ~&ovf_count_o) ? ovf_count_o + CNT_W'(1) : ovf_count_o;
    end
  end
endmodule

// File: tb/tb_adder_pipe_stage.sv
// tb_adder_pipe_stage: scoreboard bench with random and directed operand streams and backpressure
module tb_adder_pipe_stage;
  localparam int W = 32;
  localparam int CW = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr = 0;
  logic [W-1:0] add1 = 0, add2 = 0;
  logic in_ready, out_valid, carry, ovf;
  logic [W-1:0] sum;
  logic [CW-1:0] cnt;
  typedef struct packed {logic [W-1:0] sum; logic carry; logic ovf;} res_t;
  res_t sb[$];
  res_t e, held;
  logic hold = 0;
  int checks = 0, errors = 0, cyc = 0, accepts = 0, cnt_m = 0;
  int xcyc[$];
  bit rnd = 0;

  adder_pipe_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .add1_i(add1), .add2_i(add2), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .carry_o(carry), .overflow_o(ovf), .ovf_count_o(cnt), .clr_count_i(clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W:0] u;
    longint s, lim;
    u = {1'b0, a} + {1'b0, b};
    s = longint'($signed(a)) + longint'($signed(b));
    lim = longint'(1) <<< (W - 1);
    r.sum = u[W-1:0];
    r.carry = u[W];
    r.ovf = (s >= lim) || (s < -lim);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cnt_m = 0;
      hold = 0;
    end else begin
      chk("ovf_count", 64'(cnt), 64'(cnt_m));
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({sum, carry, ovf}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got sum %0h expected no result", sum);
        end else begin
          e = sb.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("carry", 64'(carry), 64'(e.carry));
          chk("overflow", 64'(ovf), 64'(e.ovf));
          xcyc.push_back(cyc);
          if (e.ovf && cnt_m < (1 << CW) - 1) cnt_m++;
        end
      end
      if (clr) cnt_m = 0;
      hold = out_valid && !out_ready;
      held = {sum, carry, ovf};
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    add1 = a;
    add2 = b;
    in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom);
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
    end else begin
      sb.push_back(model(a, b));
      accepts++;
    end
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom);
  endtask

  task automatic idle();
    in_valid = 0;
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    out_ready = 1;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                     input logic c, input logic o);
    out_ready = 1;
    send(a, b);
    in_valid = 0;
    @(negedge clk);
    chk("latency_k", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_k1", 64'(out_valid), 64'd1);
    chk("dir_sum", 64'(sum), 64'(s));
    chk("dir_carry", 64'(carry), 64'(c));
    chk("dir_ovf", 64'(ovf), 64'(o));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, a0;
    logic [W-1:0] sa[10], sb_op[10];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 0;
    @(posedge clk);
    #1;
    dir(32'h7fffffff, 32'd1, 32'h80000000, 1'b0, 1'b1);
    @(negedge clk);
    chk("count_after_imax", 64'(cnt), 64'd1);
    @(posedge clk);
    #1;
    dir(32'h80000000, 32'hffffffff, 32'h7fffffff, 1'b1, 1'b1);
    dir(32'd51, -32'sd55, -32'sd4, 1'b0, 1'b0);
    sa[0] = 250; sb_op[0] = 350;
    sa[1] = -13; sb_op[1] = 13;
    sa[2] = -2000000000; sb_op[2] = -32;
    for (int i = 3; i < 10; i++) begin
      sa[i] = $urandom;
      sb_op[i] = $urandom;
    end
    n0 = xcyc.size();
    out_ready = 1;
    for (int i = 0; i < 10; i++) send(sa[i], sb_op[i]);
    drain();
    if (xcyc.size() < n0 + 10) chk("stream_count", 64'(xcyc.size() - n0), 64'd10);
    else chk("stream_consecutive", 64'(xcyc[n0+9] - xcyc[n0]), 64'd9);
    out_ready = 0;
    a0 = accepts;
    fork
      begin
        for (int i = 0; i < 4; i++) send($urandom, $urandom);
        in_valid = 0;
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", 64'(accepts - a0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    rnd = 1;
    repeat (200) begin
      if ($urandom_range(3) != 0) send($urandom, $urandom);
      else idle();
    end
    rnd = 0;
    drain();
    out_ready = 1;
    repeat (300) send(32'h7fffffff, W'($urandom_range(1, 1000)));
    drain();
    chk("count_saturated", 64'(cnt), 64'd255);
    send(32'h7fffffff, 32'd5);
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("clr_pending_ovf", 64'(out_valid & ovf), 64'd1);
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    chk("clr_priority", 64'(cnt), 64'd0);
    drain();
    out_ready = 0;
    send(32'd1, 32'd2);
    send(32'd3, 32'd4);
    in_valid = 0;
    chk("full_before_rst", 64'(in_ready), 64'd0);
    rst = 1;
    #1;
    sb.delete();
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_count", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    dir(32'd100, -32'sd300, -32'sd200, 1'b0, 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_pipe_stage.md
Name: adder_pipe_stage

Overview:
- Registered two-stage valid/ready wrapper that feeds operand pairs into a WIDTH-bit signed adder and captures the results.
- Produces sum, unsigned carry-out and a signed-overflow flag, and counts overflowing results.
- Sits between the operand source and the result consumer, so any combinational adder core can run at a registered, back-pressurable boundary.

Parameters:
- WIDTH, 32, operand and sum width in bits (signed two's complement).
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  operand pair on add1_i/add2_i is valid.
- in_ready_o  output  1  stage can accept an operand pair this cycle.
- add1_i  input  WIDTH  signed operand 1.
- add2_i  input  WIDTH  signed operand 2.
- out_valid_o  output  1  result on sum_o/carry_o/overflow_o is valid.
- out_ready_i  input  1  consumer accepts the result this cycle.
- sum_o  output  WIDTH  signed sum, modulo 2^WIDTH.
- carry_o  output  1  unsigned carry-out of bit WIDTH-1.
- overflow_o  output  1  signed overflow of this result.
- ovf_count_o  output  CNT_W  number of transferred results with overflow_o=1, saturating.
- clr_count_i  input  1  synchronous clear of ovf_count_o.

Behaviour:
- Reset is asynchronous, active-high; clk and rst are the only clock and reset.
- Reset values: out_valid_o=0, sum_o=0, carry_o=0, overflow_o=0, ovf_count_o=0, internal s1_valid=0, operand registers=0.
- in_ready_o=1 during and after reset.
- Input transfer: in_valid_i & in_ready_o at a rising edge.
- Output transfer: out_valid_o & out_ready_i at a rising edge.
- Stage 1: on input transfer, captures add1_i/add2_i into operand registers and sets s1_valid.
- Stage 2: registers the adder output as follows.
  - {carry_o, sum_o} = zero-extended add1 + add2, (WIDTH+1)-bit.
  - overflow_o = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
- s2_free = !out_valid_o | out_ready_i.
- in_ready_o = !s1_valid | s2_free; combinational, no dependency on in_valid_i.
- Stage 2 loads when s1_valid & s2_free; out_valid_o then becomes 1.
- If s2_free & !s1_valid, out_valid_o clears.
- s1_valid clears when stage 2 loads and no new input transfer occurs in the same cycle.
- Latency: an operand pair accepted at edge k appears on out_valid_o after edge k+1 and can transfer at edge k+2.
- Throughput is 1 result/cycle with out_ready_i held high.
- Backpressure: while out_valid_o=1 and out_ready_i=0, sum_o/carry_o/overflow_o hold stable.
  - Stage 1 holds one pending pair.
  - in_ready_o=0 once both stages are full.
  - No pair is dropped or duplicated.
- Simultaneous events:
  - Output transfer and stage-2 load in the same cycle: the new result replaces the old.
  - Input transfer while stage 1 drains: the new pair is captured.
- Counter: increments by 1 on an output transfer with overflow_o=1; holds at 2^CNT_W-1, no wrap.
- clr_count_i has priority over an increment in the same cycle; the result is 0.
- Reset mid-operation discards both stages with no output transfer. The first input accepted after reset appears two edges later.
- The arithmetic wraps; no saturation of sum_o. Carry and overflow are independent flags.

Test Plan:
- INT32_MAX + 1, out_ready_i=1 → sum_o=0x80000000, carry_o=0, overflow_o=1, valid 2 edges after accept; ovf_count_o=1 after transfer.
- 0x80000000 + (-1) → sum_o=0x7FFFFFFF, carry_o=1, overflow_o=1; 51 + (-55) → sum_o=-4, carry_o=0, overflow_o=0.
- Stream of 10 pairs back-to-back, including (250,350)→600, (-13,13)→0 and (-2000000000,-32)→-2000000032, with out_ready_i=1 → 10 results in order on 10 consecutive cycles.
- Hold out_ready_i=0 for 5 cycles during the stream → in_ready_o drops after 2 accepts, outputs stable, no loss or reorder after release.
- Drive 300 overflowing sums with CNT_W=8 → ovf_count_o saturates at 255; assert clr_count_i on the same cycle as an overflowing transfer → ovf_count_o=0.
- Assert rst with both stages full → out_valid_o=0 immediately (asynchronous), in_ready_o=1; a pair sent after deassertion gives a correct result 2 edges later.
